// File: rtl/piso_tx_controller.sv
// Control FSM and bit counter for the UART transmit PISO path: it loads once per frame, then shifts once per bit slot.
// The optional parity slot is enabled by defining UART_PARITY_EN.
module piso_tx_controller #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 4
) (
  input  logic             baud_clk,
  input  logic             rst,
  input  logic             send,
  input  logic             cfg_stop2,
  output logic             ready,
  output logic             busy,
  output logic             load,
  output logic             shift,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             parity_slot,
  output logic             frame_done
);

`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  // Index of the last bit slot when there is one stop bit. A second stop bit adds one.
  localparam logic [CNT_W-1:0] LAST_BASE = CNT_W'(DATA_BITS + PAR + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_stop2;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] w_last;
  logic             w_last_bit;

  assign w_last     = LAST_BASE + CNT_W'(r_stop2);
  assign w_last_bit = (r_bit_cnt == w_last);

  always_ff @(posedge baud_clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (send) w_next = S_LOAD;
      S_LOAD:  w_next = S_SHIFT;
      S_SHIFT: if (w_last_bit) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The counter is held at 0 outside SHIFT, so bit_cnt needs no output gating.
  always_ff @(posedge baud_clk) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_stop2   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && send) r_stop2 <= cfg_stop2;
      if (r_state == S_SHIFT && !w_last_bit) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      else                                   r_bit_cnt <= '0;
    end
  end

  assign ready      = (r_state == S_IDLE);
  assign busy       = !ready;
  assign load       = (r_state == S_LOAD);
  assign shift      = (r_state == S_SHIFT);
  assign bit_cnt    = r_bit_cnt;
  assign frame_done = shift && w_last_bit;

`ifdef UART_PARITY_EN
  localparam logic [CNT_W-1:0] PAR_IDX = CNT_W'(DATA_BITS + 1);
  assign parity_slot = shift && (r_bit_cnt == PAR_IDX);
`else
  assign parity_slot = 1'b0;
`endif

endmodule

// File: tb/tb_piso_tx_controller.sv
// Self-checking bench for piso_tx_controller. It uses a cycle-timing reference model.
// The model derives every output from the accept cycle and the frame length.
module tb_piso_tx_controller;
  localparam int DB = 8;
  localparam int CW = 4;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic          baud_clk = 1'b0;
  logic          rst = 1'b1, send = 1'b0, cfg_stop2 = 1'b0;
  logic          ready, busy, load, shift, parity_slot, frame_done;
  logic [CW-1:0] bit_cnt;

  int checks = 0, failures = 0;
  int cyc = 0;

  // Reference model: the last accepted frame (accept cycle, length) and the cycle ready returns.
  bit m_active = 0;
  int m_a = 0, m_L = 0, m_ready_at = 0;

  piso_tx_controller #(.DATA_BITS(DB), .CNT_W(CW)) dut (
    .baud_clk(baud_clk), .rst(rst), .send(send), .cfg_stop2(cfg_stop2),
    .ready(ready), .busy(busy), .load(load), .shift(shift),
    .bit_cnt(bit_cnt), .parity_slot(parity_slot), .frame_done(frame_done)
  );

  always #5 baud_clk = ~baud_clk;

  function automatic logic [9:0] obs();
    return {ready, busy, load, shift, bit_cnt, parity_slot, frame_done};
  endfunction

  function automatic int flen(input logic s2);
    return 1 + DB + P + 1 + int'(s2);
  endfunction

  // Expected outputs in cycle t: relative cycle 1 is the load cycle and relative cycles 2 to L+1 are the shift slots.
  function automatic logic [9:0] exp_out(input int t);
    int rel, cnt;
    if (!m_active || t >= m_ready_at) return {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    rel = t - m_a;
    if (rel == 1) return {1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    cnt = rel - 2;
    return {1'b0, 1'b1, 1'b0, 1'b1, 4'(cnt), (P == 1 && cnt == DB + 1), (cnt == m_L - 1)};
  endfunction

  // Drive the inputs for cycle cyc (they are sampled at the next rising edge) and advance the model.
  task automatic step(input logic s, input logic c, input logic r);
    send = s; cfg_stop2 = c; rst = r;
    if (r) m_active = 0;
    else if ((!m_active || cyc >= m_ready_at) && s) begin
      m_active = 1; m_a = cyc; m_L = flen(c); m_ready_at = cyc + 2 + m_L;
    end
    cyc++;
  endtask

  task automatic test_reset();
    @(negedge baud_clk); step(0, 0, 1);
    @(negedge baud_clk); step(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge baud_clk);
      checks++;
      if (obs() !== exp_out(cyc)) begin
        failures++; $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, obs(), exp_out(cyc));
      end
      step(0, 0, 0);
    end
  endtask

  // Single frame with the given stop2 setting; optionally scramble cfg_stop2 during the frame.
  task automatic test_frame(input logic s2, input bit toggle, input string nm);
    int nshift = 0, done_rel = -1, npar = 0, par_rel = -1, L;
    L = flen(s2);
    for (int rel = 0; rel < L + 4; rel++) begin
      @(negedge baud_clk);
      checks++;
      if (obs() !== exp_out(cyc)) begin
        failures++; $display("FAIL %s cyc=%0d rel=%0d got=%b exp=%b", nm, cyc, rel, obs(), exp_out(cyc));
      end
      if (shift) nshift++;
      if (frame_done) done_rel = rel;
      if (parity_slot) begin npar++; par_rel = rel; end
      step(rel == 0, (rel == 0 || !toggle) ? s2 : 1'($urandom_range(0, 1)), 0);
    end
    checks++;
    if (nshift != L) begin failures++; $display("FAIL %s_nshift got=%0d exp=%0d", nm, nshift, L); end
    checks++;
    if (done_rel != L + 1) begin failures++; $display("FAIL %s_done_at got=%0d exp=%0d", nm, done_rel, L + 1); end
    checks++;
    if (npar != P || (P == 1 && par_rel != DB + 3)) begin
      failures++; $display("FAIL %s_parity count=%0d at=%0d exp_count=%0d exp_at=%0d", nm, npar, par_rel, P, DB + 3);
    end
  endtask

  task automatic test_back_to_back();
    int loads[$];
    int L;
    L = flen(1'b0);
    for (int rel = 0; rel < 3 * (L + 2); rel++) begin
      @(negedge baud_clk);
      checks++;
      if (obs() !== exp_out(cyc)) begin
        failures++; $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, obs(), exp_out(cyc));
      end
      if (load) loads.push_back(rel);
      step(1, 0, 0);
    end
    checks++;
    if (loads.size() != 3 || loads[0] != 1 || loads[1] != 1 + (L + 2) || loads[2] != 1 + 2 * (L + 2)) begin
      failures++;
      $display("FAIL b2b_load_times got_n=%0d first=%0d exp=1,%0d,%0d", loads.size(),
               loads.size() > 0 ? loads[0] : -1, 1 + (L + 2), 1 + 2 * (L + 2));
    end
    // Let the third frame drain before the next test starts.
    for (int rel = 0; rel < L + 2; rel++) begin
      @(negedge baud_clk);
      checks++;
      if (obs() !== exp_out(cyc)) begin
        failures++; $display("FAIL b2b_drain cyc=%0d got=%b exp=%b", cyc, obs(), exp_out(cyc));
      end
      step(0, 0, 0);
    end
  endtask

  task automatic test_busy_ignore();
    int nload = 0, nshift = 0;
    for (int rel = 0; rel < 16; rel++) begin
      @(negedge baud_clk);
      checks++;
      if (obs() !== exp_out(cyc)) begin
        failures++; $display("FAIL busy_ign cyc=%0d got=%b exp=%b", cyc, obs(), exp_out(cyc));
      end
      if (load) nload++;
      if (shift) nshift++;
      step(rel == 0 || rel == 4 || rel == 7, 0, 0);
    end
    checks++;
    if (nload != 1 || nshift != flen(1'b0)) begin
      failures++; $display("FAIL busy_ign_counts loads=%0d shifts=%0d exp=1,%0d", nload, nshift, flen(1'b0));
    end
  endtask

  task automatic test_mid_reset();
    int ndone = 0;
    for (int rel = 0; rel < 14; rel++) begin
      @(negedge baud_clk);
      checks++;
      if (obs() !== exp_out(cyc)) begin
        failures++; $display("FAIL mid_rst cyc=%0d rel=%0d got=%b exp=%b", cyc, rel, obs(), exp_out(cyc));
      end
      if (frame_done) ndone++;
      step(rel == 0, 0, rel == 6);
    end
    checks++;
    if (ndone != 0) begin failures++; $display("FAIL mid_rst_done got=%0d exp=0", ndone); end
    test_frame(1'b0, 0, "restart");
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge baud_clk);
      checks++;
      if (obs() !== exp_out(cyc)) begin
        failures++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs(), exp_out(cyc));
      end
      step($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_frame(1'b0, 0, "frame_stop1");
    test_frame(1'b1, 1, "frame_stop2_toggle");
    test_frame(1'b0, 1, "frame_stop1_toggle");
    test_back_to_back();
    test_busy_ignore();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
